// File: rtl/galaksija_kbd_pkg.sv
// Shared definitions for the Galaksija keyboard sequencer: matrix indices,
// sequencer states and the queued key entry format.
package galaksija_kbd_pkg;

  localparam logic [5:0] KEY_SHIFT = 6'd53;
  localparam logic [5:0] KEY_ENTER = 6'd48;
  localparam logic [5:0] KEY_BREAK = 6'd49;
  localparam logic [5:0] KEY_LEFT  = 6'd29;
  localparam logic [5:0] KEY_SPACE = 6'd31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } kbd_state_t;

  typedef struct packed {
    logic       shift;
    logic [5:0] key;
  } key_entry_t;

  // Index 0 and 54..63 have no physical key behind them.
  function automatic logic is_matrix_key(input logic [5:0] idx);
    return (idx != 6'd0) && (idx <= KEY_SHIFT);
  endfunction

endpackage

// File: rtl/galaksija_ascii_keymap.sv
// Combinational ASCII to Galaksija matrix translation; bytes without a key
// come out with valid low.
module galaksija_ascii_keymap
  import galaksija_kbd_pkg::*;
(
  input  logic [7:0] data,
  output logic       valid,
  output logic       shift,
  output logic [5:0] key
);

  // Letters, digits and the shifted 0x21..0x29 run are contiguous; the rest are single codes
  always_comb begin
    valid = 1'b1;
    shift = 1'b0;
    key   = 6'd0;
    if (data >= 8'h41 && data <= 8'h5A) begin
      key = 6'(data - 8'h40);
    end else if (data >= 8'h61 && data <= 8'h7A) begin
      key = 6'(data - 8'h60);
    end else if (data >= 8'h30 && data <= 8'h39) begin
      key = 6'(data - 8'h10);
    end else if (data >= 8'h21 && data <= 8'h29) begin
      shift = 1'b1;
      key   = data[5:0];
    end else begin
      case (data)
        8'h5F: begin shift = 1'b1; key = 6'd32; end
        8'h2B: begin shift = 1'b1; key = 6'd42; end
        8'h2A: begin shift = 1'b1; key = 6'd43; end
        8'h3C: begin shift = 1'b1; key = 6'd44; end
        8'h2D: begin shift = 1'b1; key = 6'd45; end
        8'h3E: begin shift = 1'b1; key = 6'd46; end
        8'h3F: begin shift = 1'b1; key = 6'd47; end
        8'h3B: key = 6'd42;
        8'h3A: key = 6'd43;
        8'h2C: key = 6'd44;
        8'h3D: key = 6'd45;
        8'h2E: key = 6'd46;
        8'h2F: key = 6'd47;
        8'h20: key = KEY_SPACE;
        8'h0A, 8'h0D: key = KEY_ENTER;
        8'h08, 8'h7F: key = KEY_LEFT;
        8'h1B: key = KEY_BREAK;
        default: begin
          valid = 1'b0;
          shift = 1'b0;
          key   = 6'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/galaksija_key_sequencer.sv
// Queues typed characters and presses each on the keyboard matrix for a fixed
// number of 50 Hz frames, then releases it, so the ROM scan sees it once.
module galaksija_key_sequencer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int PRESS_FRAMES   = 3,
  parameter int RELEASE_FRAMES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          frame_tick,
  input  logic                          key_rd,
  input  logic [5:0]                    key_addr,
  output logic [7:0]                    key_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  import galaksija_kbd_pkg::*;

  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int LW         = AW + 1;
  localparam int MAX_FRAMES = (PRESS_FRAMES > RELEASE_FRAMES) ? PRESS_FRAMES : RELEASE_FRAMES;
  localparam int CW         = $clog2(MAX_FRAMES) + 1;

  localparam logic [LW-1:0] FIFO_FULL    = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_FRAMES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_FRAMES - 1);

  logic            map_valid_s;
  logic            map_shift_s;
  logic [5:0]      map_key_s;
  key_entry_t      rx_entry_s;

  key_entry_t      fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   count_r;
  logic            overflow_r;

  kbd_state_t      state_r;
  kbd_state_t      state_nxt_s;
  logic [CW-1:0]   frame_cnt_r;
  logic [CW-1:0]   frame_cnt_nxt_s;
  key_entry_t      cur_r;
  logic [7:0]      key_out_r;

  logic            push_req_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            pressed_s;

  galaksija_ascii_keymap u_keymap (
    .data  (rx_data),
    .valid (map_valid_s),
    .shift (map_shift_s),
    .key   (map_key_s)
  );

  assign rx_entry_s = {map_shift_s, map_key_s};

  // Push arbitration: a full queue still takes a byte when the head leaves the same cycle
  always_comb begin
    push_req_s = rx_valid & map_valid_s;
    full_s     = (count_r == FIFO_FULL);
    push_s     = push_req_s & (~full_s | pop_s);
  end

  // Sequencer next state; a tick on the IDLE->PRESS cycle is deliberately ignored
  always_comb begin
    state_nxt_s     = state_r;
    frame_cnt_nxt_s = frame_cnt_r;
    pop_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != {LW{1'b0}}) begin
          pop_s           = 1'b1;
          frame_cnt_nxt_s = {CW{1'b0}};
          state_nxt_s     = PRESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESS: begin
        if (frame_tick) begin
          if (frame_cnt_r == PRESS_LAST) begin
            frame_cnt_nxt_s = {CW{1'b0}};
            state_nxt_s     = RELEASE;
          end else begin
            frame_cnt_nxt_s = frame_cnt_r + CW'(1'b1);
          end
        end else begin
          frame_cnt_nxt_s = frame_cnt_r;
        end
      end
      RELEASE: begin
        if (frame_tick) begin
          if (frame_cnt_r == RELEASE_LAST) begin
            frame_cnt_nxt_s = {CW{1'b0}};
            state_nxt_s     = IDLE;
          end else begin
            frame_cnt_nxt_s = frame_cnt_r + CW'(1'b1);
          end
        end else begin
          frame_cnt_nxt_s = frame_cnt_r;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        frame_cnt_nxt_s = {CW{1'b0}};
      end
    endcase
  end

  // Matrix decode for the addressed index while a key is held
  always_comb begin
    if (state_r == PRESS && is_matrix_key(key_addr)) begin
      pressed_s = (key_addr == cur_r.key) | (cur_r.shift & (key_addr == KEY_SHIFT));
    end else begin
      pressed_s = 1'b0;
    end
  end

  // Queue storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= rx_entry_s;
    end
  end

  // Control state; reset drops the held key and flushes the queue immediately
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      frame_cnt_r <= {CW{1'b0}};
      cur_r       <= {1'b0, 6'd0};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {LW{1'b0}};
      overflow_r  <= 1'b0;
      key_out_r   <= 8'hFF;
    end else begin
      state_r     <= state_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      if (pop_s) begin
        cur_r    <= fifo_mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LW'(1'b1);
        2'b01:   count_r <= count_r - LW'(1'b1);
        default: count_r <= count_r;
      endcase
      if (push_req_s & full_s & ~pop_s) begin
        overflow_r <= 1'b1;
      end
      if (key_rd) begin
        key_out_r <= pressed_s ? 8'hFE : 8'hFF;
      end
    end
  end

  assign key_out    = key_out_r;
  assign busy       = (state_r != IDLE);
  assign fifo_level = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_galaksija_key_sequencer.sv
// Directed bench for galaksija_key_sequencer: mapping, press/release timing,
// FIFO overflow and pop/push collision, and reset mid-press.
module tb_galaksija_key_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_tick;
  logic       key_rd;
  logic [5:0] key_addr;
  logic [7:0] key_out;
  logic       busy;
  logic [4:0] fifo_level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  galaksija_key_sequencer #(
    .FIFO_DEPTH     (16),
    .PRESS_FRAMES   (3),
    .RELEASE_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_tick (frame_tick),
    .key_rd     (key_rd),
    .key_addr   (key_addr),
    .key_out    (key_out),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic read_key(input logic [5:0] a, output logic [7:0] d);
    key_rd   = 1'b1;
    key_addr = a;
    step();
    key_rd   = 1'b0;
    d        = key_out;
  endtask

  logic [7:0] rd;
  logic [7:0] map_bytes [8] = '{8'h3B, 8'h3F, 8'h7A, 8'h0D, 8'h7F, 8'h1B, 8'h20, 8'h27};
  logic [5:0] map_keys  [8] = '{6'd42, 6'd47, 6'd26, 6'd48, 6'd29, 6'd49, 6'd31, 6'd39};
  logic       map_shift [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    frame_tick = 1'b0; key_rd = 1'b0; key_addr = 6'd0;
    step(); step(); step();
    check_val("rst_key_out", key_out, 8'hFF);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_level", fifo_level, 5'd0);
    check_val("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    step();

    // 'A', with a tick on the IDLE->PRESS cycle that must not count
    send_byte(8'h41);
    tick();
    check_val("A_busy", busy, 1'b1);
    read_key(6'd1, rd);  check_val("A_key1_pressed", rd, 8'hFE);
    read_key(6'd53, rd); check_val("A_shift_free", rd, 8'hFF);
    read_key(6'd0, rd);  check_val("A_idx0_free", rd, 8'hFF);
    tick(); tick();
    read_key(6'd1, rd);  check_val("A_held_after_2", rd, 8'hFE);
    tick();
    read_key(6'd1, rd);  check_val("A_released", rd, 8'hFF);
    check_val("A_busy_release", busy, 1'b1);
    tick();
    check_val("A_busy_gap", busy, 1'b1);
    tick();
    check_val("A_busy_done", busy, 1'b0);

    // '!' presses 33 together with SHIFT
    send_byte(8'h21);
    step();
    read_key(6'd33, rd); check_val("excl_key33", rd, 8'hFE);
    read_key(6'd53, rd); check_val("excl_shift", rd, 8'hFE);
    tick(); tick(); tick();
    read_key(6'd33, rd); check_val("excl_key33_rel", rd, 8'hFF);
    read_key(6'd53, rd); check_val("excl_shift_rel", rd, 8'hFF);
    tick(); tick();
    check_val("excl_idle", busy, 1'b0);

    // Unmapped bytes are ignored
    send_byte(8'h07);
    send_byte(8'h80);
    step();
    check_val("unmapped_level", fifo_level, 5'd0);
    check_val("unmapped_busy", busy, 1'b0);
    check_val("unmapped_overflow", overflow, 1'b0);

    // Mapping table: each byte pressed once, with SHIFT where expected
    for (int i = 0; i < 8; i++) begin
      send_byte(map_bytes[i]);
      step();
      read_key(map_keys[i], rd);
      check_val($sformatf("map_key_%0d", i), rd, 8'hFE);
      read_key(6'd53, rd);
      check_val($sformatf("map_shift_%0d", i), rd, map_shift[i] ? 8'hFE : 8'hFF);
      tick(); tick(); tick(); tick(); tick();
      check_val($sformatf("map_done_%0d", i), busy, 1'b0);
    end

    // Burst "0123456789ABCDEFGH" while '0' is pressed: 16 queued, 'H' dropped
    send_byte(8'h30);
    step();
    for (int i = 1; i < 18; i++) begin
      send_byte((i < 10) ? (8'h30 + 8'(i)) : (8'h41 + 8'(i - 10)));
    end
    check_val("burst_level", fifo_level, 5'd16);
    check_val("burst_overflow", overflow, 1'b1);
    for (int k = 0; k < 18; k++) begin
      logic [5:0] ek;
      ek = (k < 10) ? 6'(32 + k) : ((k < 17) ? 6'(k - 9) : 6'd9);
      read_key(ek, rd);
      check_val($sformatf("replay_press_%0d", k), rd, 8'hFE);
      tick(); tick(); tick();
      read_key(ek, rd);
      check_val($sformatf("replay_rel_%0d", k), rd, 8'hFF);
      tick(); tick();
      if (k == 0) begin
        // full FIFO, push lands on the pop cycle: accepted, level unchanged
        send_byte(8'h49);
        check_val("collide_level", fifo_level, 5'd16);
        check_val("collide_overflow", overflow, 1'b1);
      end else if (k < 17) begin
        step();
        check_val($sformatf("replay_level_%0d", k), fifo_level, 5'(16 - k));
      end else begin
        check_val("replay_end_busy", busy, 1'b0);
        check_val("replay_end_level", fifo_level, 5'd0);
      end
    end

    // Reset mid-press of 'Z' with 4 queued
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_val("rst2_overflow_clr", overflow, 1'b0);
    send_byte(8'h5A);
    step();
    send_byte(8'h42); send_byte(8'h43); send_byte(8'h44); send_byte(8'h45);
    check_val("z_level", fifo_level, 5'd4);
    read_key(6'd26, rd); check_val("z_pressed", rd, 8'hFE);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_val("z_rst_key_out", key_out, 8'hFF);
    read_key(6'd26, rd); check_val("z_rst_read", rd, 8'hFF);
    check_val("z_rst_level", fifo_level, 5'd0);
    check_val("z_rst_busy", busy, 1'b0);
    check_val("z_rst_overflow", overflow, 1'b0);
    step(); step();
    check_val("z_rst_stays_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/galaksija_key_sequencer.md
Name: galaksija_key_sequencer

Overview:
Schedules typed characters from the serial keyboard onto the Galaksija keyboard matrix read by the CPU at 0x2000-0x27FF. It buffers incoming UART bytes and maps each to a matrix key plus optional SHIFT. Each key is held pressed for a fixed number of 50 Hz frames, then released, so the ROM scan routine sees every keystroke exactly once. It replaces the direct UART-to-keys[] logic in the top level and sits between uart_rx, the 50 Hz interrupt generator and the CPU read mux.

Parameters:
FIFO_DEPTH, 16, character buffer entries; power of two, at least 2
PRESS_FRAMES, 3, frame_tick pulses a key stays pressed; at least 1
RELEASE_FRAMES, 2, frame_tick pulses all keys stay released between characters; at least 1

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
frame_tick  in  1  one-cycle pulse per 50 Hz frame (int_n low cycle)
key_rd  in  1  CPU read of keyboard region this cycle
key_addr  in  6  matrix index, addr[5:0]
key_out  out  8  registered matrix read data
busy  out  1  a character is in PRESS or RELEASE
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries queued
overflow  out  1  sticky: a mapped byte was dropped because the FIFO was full

Behaviour:
- Reset values: key_out=8'hFF, busy=0, fifo_level=0, overflow=0, FSM=IDLE, no key pressed. Reset mid-press releases all keys and flushes the FIFO at once.
- Mapping (galaksija_ascii_keymap, combinational): 'A'-'Z' and 'a'-'z' map to 1..26. '0'-'9' map to 32..41. Space maps to 31. LF/CR map to 48. BS/DEL map to 29. ESC maps to 49.
- Shifted mapping, SHIFT key 53 asserted too: '_'32 '!'33 '"'34 '#'35 '$'36 '%'37 '&'38 '\'39 '('40 ')'41 '+'42 '*'43 '<'44 '-'45 '>'46 '?'47.
- Unshifted punctuation: ';'42 ':'43 ','44 '='45 '.'46 '/'47.
- Any other byte: valid=0, never enqueued, overflow unaffected.
- FIFO entry is 7 bits: {shift, key[5:0]}. Write happens at the edge closing the rx_valid cycle.
- FIFO full plus a mapped rx_valid: byte dropped, overflow<=1 (sticky until reset). Exception: if a pop occurs in the same cycle, the push is accepted and the level is unchanged.
- Empty FIFO is never popped.
- FSM IDLE: when the FIFO is non-empty, pop the head into cur_key/cur_shift, clear frame_cnt, go to PRESS.
- A byte with rx_valid in cycle T in IDLE with an empty FIFO: pressed key visible from cycle T+2.
- PRESS: busy=1. Matrix index cur_key is pressed; index 53 is also pressed if cur_shift.
- PRESS counting: each frame_tick increments frame_cnt. On the tick where frame_cnt==PRESS_FRAMES-1, clear frame_cnt and go to RELEASE.
- A tick in the same cycle as the IDLE->PRESS transition is not counted.
- RELEASE: busy=1, no key pressed. Exit on the RELEASE_FRAMES-th tick to IDLE; the next pop happens the following cycle.
- Matrix read: on key_rd, key_out <= pressed(key_addr) ? 8'hFE : 8'hFF; otherwise key_out holds. Index 0 and indices 54-63 are never pressed. One-cycle read latency, matching the ROM/RAM read timing.
- rx_valid during PRESS/RELEASE only enqueues; the current key is not disturbed.
- frame_cnt width is $clog2(max(PRESS_FRAMES,RELEASE_FRAMES))+1; no wrap is possible.

Decomposition:
- Shared package galaksija_kbd_pkg: KEY_SHIFT=53, KEY_ENTER=48, KEY_BREAK=49, KEY_LEFT=29, KEY_SPACE=31; FSM state enum {IDLE, PRESS, RELEASE}; 7-bit key entry typedef.
- Sub-module galaksija_ascii_keymap: byte in, {valid, shift, key[5:0]} out, purely combinational.
- FIFO stays inline: pointer pair plus count.

Test Plan:
- Reset, then rx 'A': in PRESS, key_rd at addr 1 returns FE and addr 53 returns FF. Key is released after the 3rd frame_tick. busy drops after 2 more ticks.
- rx '!': addr 33 and addr 53 both read FE during PRESS; both read FF in RELEASE.
- rx 0x07, then 0x80: nothing enqueued, fifo_level stays 0, busy stays 0, overflow stays 0.
- Burst of 18 mapped bytes "0123456789ABCDEFGH" at back-to-back UART rate while the first is pressing: first popped, 16 queued, last dropped. overflow=1. Keys are replayed in order 32..41, 1..7, each for 3 ticks with 2-tick gaps.
- Full FIFO, rx_valid in the same cycle as the RELEASE->IDLE pop: byte accepted, fifo_level unchanged at 16, overflow unchanged.
- Assert reset_n=0 mid-PRESS of 'Z' with 4 queued: next cycle key_out read of addr 26 gives FF, fifo_level=0, busy=0, overflow=0.
